decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 136 +++++++++++++
 tb/tb_decode_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Single-entry decode pipeline stage for a MIPS integer subset: decodes on accept,
// holds the registered bundle under backpressure and keeps saturating statistics.
module decode_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_write_reg,
   output logic [5:0]       out_alu_control,
   output logic [4:0]       out_rs,
   output logic [4:0]       out_rt,
   output logic [4:0]       out_rd,
   output logic [XLEN-1:0]  out_imm,
   output logic             out_use_imm,
   output logic             out_illegal,
   output logic [CNT_W-1:0] cnt_decoded,
   output logic [CNT_W-1:0] cnt_illegal
);

   typedef enum logic [5:0] {
      OP_RTYPE = 6'b000000,
      OP_ADDIU = 6'b001001,
      OP_ORI   = 6'b001101,
      OP_LUI   = 6'b001111
   } opcode_e;

   typedef enum logic [5:0] {
      FN_ADDU = 6'b100001,
      FN_SUBU = 6'b100011,
      FN_AND  = 6'b100100,
      FN_OR   = 6'b100101,
      FN_SLT  = 6'b101010
   } func_e;

   logic            in_fire;
   logic            d_write_reg;
   logic [5:0]      d_alu_control;
   logic [4:0]      d_rd;
   logic [XLEN-1:0] d_imm;
   logic            d_use_imm;
   logic            d_illegal;

   assign in_ready = (!out_valid || out_ready) && !flush;
   assign in_fire  = in_valid && in_ready;

   // Defaults describe the illegal encoding; each supported case overrides them.
   always_comb begin
      d_write_reg   = 1'b0;
      d_alu_control = '1;
      d_rd          = in_instr[15:11];
      d_imm         = '0;
      d_use_imm     = 1'b0;
      d_illegal     = 1'b1;
      case (in_instr[31:26])
         OP_RTYPE: begin
            case (in_instr[5:0])
               FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
                  d_write_reg   = 1'b1;
                  d_alu_control = in_instr[5:0];
                  d_illegal     = 1'b0;
               end
               default: ;
            endcase
         end
         OP_ADDIU: begin
            d_write_reg   = 1'b1;
            d_alu_control = FN_ADDU;
            d_rd          = in_instr[20:16];
            d_imm         = XLEN'($signed(in_instr[15:0]));
            d_use_imm     = 1'b1;
            d_illegal     = 1'b0;
         end
         OP_ORI: begin
            d_write_reg   = 1'b1;
            d_alu_control = FN_OR;
            d_rd          = in_instr[20:16];
            d_imm         = XLEN'(in_instr[15:0]);
            d_use_imm     = 1'b1;
            d_illegal     = 1'b0;
         end
         OP_LUI: begin
            d_write_reg   = 1'b1;
            d_alu_control = FN_OR;
            d_rd          = in_instr[20:16];
            d_imm         = XLEN'({in_instr[15:0], 16'h0000});
            d_use_imm     = 1'b1;
            d_illegal     = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid       <= 1'b0;
         out_write_reg   <= 1'b0;
         out_alu_control <= '1;
         out_rs          <= '0;
         out_rt          <= '0;
         out_rd          <= '0;
         out_imm         <= '0;
         out_use_imm     <= 1'b0;
         out_illegal     <= 1'b0;
         cnt_decoded     <= '0;
         cnt_illegal     <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (in_fire) begin
         out_valid       <= 1'b1;
         out_write_reg   <= d_write_reg;
         out_alu_control <= d_alu_control;
         out_rs          <= in_instr[25:21];
         out_rt          <= in_instr[20:16];
         out_rd          <= d_rd;
         out_imm         <= d_imm;
         out_use_imm     <= d_use_imm;
         out_illegal     <= d_illegal;
         if (cnt_decoded != '1) begin
            cnt_decoded <= cnt_decoded + CNT_W'(1);
         end
         if (d_illegal && (cnt_illegal != '1)) begin
            cnt_illegal <= cnt_illegal + CNT_W'(1);
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios followed by random traffic, all checked
// against a rule-level reference decoder and handshake model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, out_ready;
   logic [31:0] in_instr;

   logic        in_ready, out_valid, out_write_reg, out_use_imm, out_illegal;
   logic [5:0]  out_alu_control;
   logic [4:0]  out_rs, out_rt, out_rd;
   logic [31:0] out_imm;
   logic [15:0] cnt_decoded, cnt_illegal;

   logic        s_in_ready, s_out_valid, s_out_write_reg, s_out_use_imm, s_out_illegal;
   logic [5:0]  s_out_alu_control;
   logic [4:0]  s_out_rs, s_out_rt, s_out_rd;
   logic [31:0] s_out_imm;
   logic [1:0]  s_cnt_decoded, s_cnt_illegal;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .out_valid(out_valid), .out_ready(out_ready),
      .out_write_reg(out_write_reg), .out_alu_control(out_alu_control),
      .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_imm(out_imm),
      .out_use_imm(out_use_imm), .out_illegal(out_illegal),
      .cnt_decoded(cnt_decoded), .cnt_illegal(cnt_illegal)
   );

   // Narrow-counter instance shares the stimulus to exercise saturation.
   decode_stage #(.XLEN(32), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_instr(in_instr), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_write_reg(s_out_write_reg), .out_alu_control(s_out_alu_control),
      .out_rs(s_out_rs), .out_rt(s_out_rt), .out_rd(s_out_rd), .out_imm(s_out_imm),
      .out_use_imm(s_out_use_imm), .out_illegal(s_out_illegal),
      .cnt_decoded(s_cnt_decoded), .cnt_illegal(s_cnt_illegal)
   );

   typedef struct packed {
      logic        wr;
      logic [5:0]  alu;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic        rd_known;
      logic [31:0] imm;
      logic        use_imm;
      logic        illegal;
   } bundle_t;

   int      checks = 0;
   int      errors = 0;
   logic    m_valid = 1'b0;
   logic    m_fields_known = 1'b0;
   bundle_t m_b;
   int      m_cnt_dec = 0;
   int      m_cnt_ill = 0;
   logic [5:0] legal_funcs [5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2A};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bundle_t ref_decode(input logic [31:0] w);
      bundle_t    b;
      logic [5:0] op, fn;
      op = w[31:26];
      fn = w[5:0];
      b.rs = w[25:21];  b.rt = w[20:16];  b.rd = w[15:11];  b.rd_known = (op == 6'd0);
      b.wr = 1'b0;  b.alu = 6'h3F;  b.imm = 32'd0;  b.use_imm = 1'b0;  b.illegal = 1'b1;
      if (op == 6'd0 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A)) begin
         b.wr = 1'b1;  b.alu = fn;  b.illegal = 1'b0;
      end else if (op == 6'h09 || op == 6'h0D || op == 6'h0F) begin
         b.wr = 1'b1;  b.illegal = 1'b0;  b.use_imm = 1'b1;  b.rd = w[20:16];  b.rd_known = 1'b1;
         b.alu = (op == 6'h09) ? 6'h21 : 6'h25;
         if (op == 6'h09)      b.imm = w[15] ? 32'hFFFF0000 + {16'h0, w[15:0]} : {16'h0, w[15:0]};
         else if (op == 6'h0D) b.imm = {16'h0, w[15:0]};
         else                  b.imm = {16'h0, w[15:0]} * 32'd65536;
      end
      return b;
   endfunction

   function automatic int sat(input int v, input int max_v);
      return (v > max_v) ? max_v : v;
   endfunction

   task automatic check_outputs();
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("cnt_decoded", {16'd0, cnt_decoded}, sat(m_cnt_dec, 65535));
      chk("cnt_illegal", {16'd0, cnt_illegal}, sat(m_cnt_ill, 65535));
      chk("sat_cnt_decoded", {30'd0, s_cnt_decoded}, sat(m_cnt_dec, 3));
      chk("sat_cnt_illegal", {30'd0, s_cnt_illegal}, sat(m_cnt_ill, 3));
      chk("sat_out_valid", {31'd0, s_out_valid}, {31'd0, m_valid});
      if (m_valid || m_fields_known) begin
         chk("write_reg", {31'd0, out_write_reg}, {31'd0, m_b.wr});
         chk("alu_control", {26'd0, out_alu_control}, {26'd0, m_b.alu});
         chk("rs", {27'd0, out_rs}, {27'd0, m_b.rs});
         chk("rt", {27'd0, out_rt}, {27'd0, m_b.rt});
         if (m_b.rd_known) chk("rd", {27'd0, out_rd}, {27'd0, m_b.rd});
         chk("imm", out_imm, m_b.imm);
         chk("use_imm", {31'd0, out_use_imm}, {31'd0, m_b.use_imm});
         chk("illegal", {31'd0, out_illegal}, {31'd0, m_b.illegal});
      end
   endtask

   task automatic step(input logic r, input logic f, input logic v, input logic [31:0] ins,
                       input logic ordy);
      bundle_t nb;
      logic    fire, drain;
      rst = r;  flush = f;  in_valid = v;  in_instr = ins;  out_ready = ordy;
      @(negedge clk);
      if (!r) chk("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || ordy) && !f});
      fire  = v && (!m_valid || ordy) && !f;
      drain = m_valid && ordy;
      nb    = ref_decode(ins);
      @(posedge clk);
      #1;
      if (r) begin
         m_valid = 1'b0;  m_fields_known = 1'b1;  m_cnt_dec = 0;  m_cnt_ill = 0;
         m_b = '0;  m_b.alu = 6'h3F;  m_b.rd_known = 1'b1;
      end else if (f) begin
         m_valid = 1'b0;  m_fields_known = 1'b0;
      end else if (fire) begin
         m_valid = 1'b1;  m_b = nb;  m_cnt_dec++;
         if (nb.illegal) m_cnt_ill++;
      end else if (drain) begin
         m_valid = 1'b0;  m_fields_known = 1'b0;
      end
      check_outputs();
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 5))
         0: begin w[31:26] = 6'h00;  w[5:0] = legal_funcs[$urandom_range(0, 4)]; end
         1: w[31:26] = 6'h09;
         2: w[31:26] = 6'h0D;
         3: w[31:26] = 6'h0F;
         4: w[31:26] = 6'h00;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      // Reset, including reset taking priority over flush and a valid input.
      step(1, 0, 0, 32'h0, 1);
      step(1, 1, 1, 32'h00851821, 1);
      chk("rst_alu", {26'd0, out_alu_control}, 32'h3F);

      // ADDU, ADDIU, LUI, ORI at full throughput.
      step(0, 0, 1, 32'h00851821, 1);
      chk("addu_valid", {31'd0, out_valid}, 32'd1);
      chk("addu_alu", {26'd0, out_alu_control}, 32'h21);
      chk("addu_rd", {27'd0, out_rd}, 32'd3);
      step(0, 0, 1, 32'h2402FFFF, 1);
      chk("addiu_imm", out_imm, 32'hFFFFFFFF);
      chk("addiu_rd", {27'd0, out_rd}, 32'd2);
      step(0, 0, 1, 32'h3C011234, 1);
      chk("lui_imm", out_imm, 32'h12340000);
      chk("lui_rd", {27'd0, out_rd}, 32'd1);
      step(0, 0, 1, 32'h3464ABCD, 1);
      chk("ori_imm", out_imm, 32'h0000ABCD);
      step(0, 0, 0, 32'h0, 1);

      // Backpressure for three cycles, then back-to-back delivery.
      step(0, 0, 1, 32'h00851821, 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 32'h00A62023, 0);
         chk("bp_hold_alu", {26'd0, out_alu_control}, 32'h21);
      end
      step(0, 0, 1, 32'h00A62023, 1);
      chk("bp_next_alu", {26'd0, out_alu_control}, 32'h23);
      step(0, 0, 1, 32'h00E8482A, 1);
      chk("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_b2b_rd", {27'd0, out_rd}, 32'd9);

      // Illegal encodings after a fresh reset.
      step(1, 0, 0, 32'h0, 1);
      step(0, 0, 1, 32'h00000000, 1);
      step(0, 0, 1, 32'h8C010000, 1);
      chk("ill_cnt_illegal", {16'd0, cnt_illegal}, 32'd2);
      chk("ill_cnt_decoded", {16'd0, cnt_decoded}, 32'd2);

      // Flush while holding a stalled bundle with a valid input waiting.
      step(0, 0, 1, 32'h00851821, 1);
      step(0, 0, 1, 32'h3C011234, 0);
      step(0, 1, 1, 32'h3C011234, 0);
      chk("flush_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_cnt", {16'd0, cnt_decoded}, 32'd3);

      // Saturation on the narrow instance, then reset mid-stream.
      step(1, 0, 0, 32'h0, 1);
      for (int i = 0; i < 5; i++) step(0, 0, 1, rand_instr(), 1);
      chk("sat_decoded_3", {30'd0, s_cnt_decoded}, 32'd3);
      chk("wide_decoded_5", {16'd0, cnt_decoded}, 32'd5);
      step(1, 0, 1, 32'h00851821, 1);
      chk("midrst_cnt", {16'd0, cnt_decoded}, 32'd0);
      chk("midrst_valid", {31'd0, out_valid}, 32'd0);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
